// File: rtl/mem_resp.sv
// mem_resp: memory-side responder for the multicycle CPU's registered
// address path. Services one read or write at a time against an internal
// word-addressed RAM after a fixed access latency, returning read data in
// a held register (MDR) with a one-cycle ack pulse and an alignment error.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   req    in   request valid, sampled only while ready=1
//   we     in   1=write, 0=read (captured with req)
//   addr   in   [31:0] byte address, word index = addr[AW+1:2]
//   wdata  in   [31:0] write data (captured with req)
//   ready  out  high only while idle (decoded from state)
//   ack    out  registered, one cycle per accepted request
//   err    out  registered, valid with ack; 1 = misaligned address
//   rdata  out  [31:0] registered read data, held between reads
module mem_resp #(
  parameter int unsigned AW      = 8,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;

  logic           we_q;
  logic           mis_q;
  logic [AW-1:0]  idx_q;
  logic [31:0]    wdata_q;

  logic           ack_q;
  logic           err_q;
  logic [31:0]    rdata_q;

  logic [31:0]    mem_q [0:(1<<AW)-1];

  logic           accept;
  logic           complete;
  logic           mem_wr;

  // Address bits above the word index alias onto the same RAM words.
  logic           unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  assign accept   = (state_q == IDLE) && req;
  // The edge that leaves BUSY with the counter exhausted is the completion
  // edge E0+LATENCY; the counter is loaded with LATENCY-1 at E0 so BUSY
  // lasts exactly LATENCY cycles, including LATENCY=1.
  assign complete = (state_q == BUSY) && (cnt_q == '0);
  assign mem_wr   = complete && we_q && !mis_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture: inputs are only looked at on the accepting edge, so
  // anything driven while BUSY/DONE cannot disturb the in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= we;
      mis_q   <= (addr[1:0] != 2'b00);
      idx_q   <= addr[AW+1:2];
      wdata_q <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (complete) begin
      ack_q <= 1'b1;
      err_q <= mis_q;
      if (!we_q && !mis_q) begin
        rdata_q <= mem_q[idx_q];
      end
    end else if (state_q == DONE) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end
  end

  // RAM contents survive reset; reset forces state to IDLE so an aborted
  // request can never reach its completion edge and write.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign ready = (state_q == IDLE);
  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_resp.sv
module tb_mem_resp;

  localparam int unsigned AW = 8;

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] data;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  function automatic void chk(input int lat, input string nm,
                              input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL L%0d %s: got %h expected %h (cycle %0d)", lat, nm, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input int lat, input string nm);
    vectors++;
    miscompares++;
    $display("FAIL L%0d %s: got none expected event (cycle %0d)", lat, nm, cyc);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned L = (g == 0) ? 3 : 1;

    logic        rst_n;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic        ready, ack, err;
    logic [31:0] rdata;
    logic        done = 1'b0;

    exp_t        sb[$];
    logic [31:0] mdl [int];
    logic [31:0] exp_rdata = '0;
    logic        prev_ack  = 1'b0;

    mem_resp #(.AW(AW), .LATENCY(L)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .ready (ready),
      .ack   (ack),
      .err   (err),
      .rdata (rdata)
    );

    // Issue one request at a negedge where ready is seen high; returns at the
    // negedge after the accepting edge with junk on the inputs and req held.
    task automatic do_req(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input bit track);
      int   n = 0;
      int   idx;
      exp_t e;
      while (!ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) fail_now(L, "ready_timeout");
      req = 1'b1; we = w; addr = a; wdata = d;
      if (track) begin
        idx    = int'((a >> 2) % (32'd1 << AW));
        e.err  = (a % 4) != 0;
        e.rd   = !w && !e.err;
        e.data = (e.rd && mdl.exists(idx)) ? mdl[idx] : '0;
        e.acc  = cyc + 1;
        if (w && !e.err) mdl[idx] = d;
        sb.push_back(e);
      end
      @(negedge clk);
      we = 1'($urandom); addr = $urandom; wdata = $urandom; req = 1'b1;
    endtask

    task automatic settle();
      int n = 0;
      while (!ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) fail_now(L, "settle_timeout");
      req = 1'b0;
    endtask

    initial begin
      logic [31:0] a;
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk(L, "post_rst_ready", 32'(ready), 32'd1);
      chk(L, "post_rst_ack",   32'(ack),   32'd0);
      chk(L, "post_rst_err",   32'(err),   32'd0);
      chk(L, "post_rst_rdata", rdata,      32'h0);
      @(negedge clk);
      repeat (10) @(negedge clk);

      do_req(1'b1, 32'h10, 32'hDEADBEEF, 1'b1); settle();
      do_req(1'b0, 32'h10, 32'h0,        1'b1); settle();
      repeat (3) @(negedge clk);
      do_req(1'b1, 32'h13, 32'h12345678, 1'b1); settle();
      do_req(1'b0, 32'h10, 32'h0,        1'b1); settle();

      do_req(1'b1, 32'h0, 32'h1, 1'b1);
      do_req(1'b1, 32'h4, 32'h2, 1'b1);
      do_req(1'b0, 32'h0, 32'h0, 1'b1);
      do_req(1'b0, 32'h4, 32'h0, 1'b1);
      do_req(1'b0, 32'h0, 32'h0, 1'b1);
      settle();

      do_req(1'b1, 32'h400, 32'hA5A5A5A5, 1'b1); settle();
      do_req(1'b0, 32'h0,   32'h0,        1'b1); settle();

      do_req(1'b1, 32'h20, 32'h0BADF00D, 1'b1); settle();
      do_req(1'b1, 32'h20, 32'hCAFEF00D, 1'b0);
      #2;
      rst_n = 1'b0;
      req   = 1'b0;
      #1;
      chk(L, "abort_ready", 32'(ready), 32'd1);
      chk(L, "abort_ack",   32'(ack),   32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_req(1'b0, 32'h20, 32'h0, 1'b1); settle();

      for (int unsigned w = 0; w < 8; w++) begin
        do_req(1'b1, 32'(w) << 2, $urandom, 1'b1);
      end
      for (int i = 0; i < 40; i++) begin
        a = ($urandom & 32'hFFFFFC00) | (32'($urandom_range(0, 7)) << 2);
        if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
        do_req(1'($urandom), a, $urandom, 1'b1);
        if ($urandom_range(0, 3) == 0) begin
          settle();
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      settle();
      repeat (3) @(negedge clk);
      if (sb.size() != 0) fail_now(L, "pending_acks");
      done = 1'b1;
    end

    always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
        chk(L, "rst_ack",   32'(ack),   32'd0);
        chk(L, "rst_ready", 32'(ready), 32'd1);
        chk(L, "rst_rdata", rdata,      32'h0);
        exp_rdata = '0;
        sb.delete();
        prev_ack  = 1'b0;
      end else begin
        if (prev_ack) chk(L, "ready_after_ack", 32'(ready), 32'd1);
        if (ack) begin
          chk(L, "ack_single", 32'(prev_ack), 32'd0);
          chk(L, "ready_during_ack", 32'(ready), 32'd0);
          if (sb.size() == 0) begin
            fail_now(L, "unexpected_ack");
          end else begin
            e = sb.pop_front();
            if (e.rd) exp_rdata = e.data;
            chk(L, "ack_latency", 32'(cyc - e.acc), 32'(L));
            chk(L, "ack_err",     32'(err),         32'(e.err));
            chk(L, "ack_rdata",   rdata,            exp_rdata);
          end
        end else begin
          chk(L, "idle_err",   32'(err), 32'd0);
          chk(L, "rdata_hold", rdata,    exp_rdata);
        end
        prev_ack = ack;
      end
    end
  end

  initial begin
    int n = 0;
    while (!(g_inst[0].done && g_inst[1].done) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) fail_now(0, "global_timeout");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
